// File: rtl/matrix_vec_mac_seq.sv
// Sequential constant-matrix by vector multiply C = A*B using one shared MAC over N*N cycles.
// Optional build macro MATRIX_VEC_SAT_EN: saturate each C element instead of wrapping.
//
// state | meaning
// IDLE  | waiting for an input vector (in_ready high)
// CALC  | one multiply-accumulate per cycle, row-major over A
// DONE  | result presented on out_c until downstream takes it
module matrix_vec_mac_seq #(
    parameter int N      = 3,
    parameter int IN_W   = 4,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter logic [N*N*COEF_W-1:0] COEFS = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*IN_W-1:0]    in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*OUT_W-1:0]   out_c,
    output logic                 busy
);
    localparam int ACC_W  = COEF_W + IN_W + $clog2(N);
    localparam int PROD_W = COEF_W + IN_W;
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int RC_W   = $clog2(N);
    localparam logic [RC_W-1:0] LAST = RC_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [RC_W-1:0]    row, col;
    logic [ACC_W-1:0]   acc, acc_sum;
    logic [N*IN_W-1:0]  b_q;
    logic [N*OUT_W-1:0] c_q;
    logic [COEF_W-1:0]  coef;
    logic [IN_W-1:0]    b_sel;
    logic [PROD_W-1:0]  prod;
    logic [EXT_W-1:0]   acc_ext;
    logic [OUT_W-1:0]   row_res;
    logic               row_end;

    always_comb begin
        coef    = COEFS[(int'(row) * N + int'(col)) * COEF_W +: COEF_W];
        b_sel   = b_q[int'(col) * IN_W +: IN_W];
        prod    = PROD_W'(coef) * PROD_W'(b_sel);
        acc_sum = acc + ACC_W'(prod);
        acc_ext = EXT_W'(acc_sum);
        row_end = (col == LAST);
`ifdef MATRIX_VEC_SAT_EN
        row_res = ((acc_ext >> OUT_W) != '0) ? '1 : acc_ext[OUT_W-1:0];
`else
        row_res = acc_ext[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (row_end && row == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
            c_q <= '0;
            acc <= '0;
            row <= '0;
            col <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                b_q <= in_b;
                acc <= '0;
                row <= '0;
                col <= '0;
            end
        end else if (state == CALC) begin
            if (row_end) begin
                c_q[int'(row) * OUT_W +: OUT_W] <= row_res;
                acc <= '0;
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                acc <= acc_sum;
                col <= col + 1'b1;
            end
        end
    end

    // rst_n gates in_ready so the block never advertises readiness while held in reset
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign out_c     = c_q;
endmodule

// File: tb/tb_matrix_vec_mac_seq.sv
// Scoreboard bench for matrix_vec_mac_seq: stimulus queues expected results, a monitor checks transfers.
module tb_matrix_vec_mac_seq;
    localparam int N = 3, IN_W = 4, COEF_W = 16, OUT_W = 16;
    localparam logic [N*N*COEF_W-1:0] A = {16'd42472, 16'd20687, 16'd10840,
                                           16'd41511, 16'd34092, 16'd21889,
                                           16'd60744, 16'd51466, 16'd2755};

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [N*IN_W-1:0]  in_b = '0;
    logic               in_ready, out_valid, busy;
    logic [N*OUT_W-1:0] out_c;

    matrix_vec_mac_seq #(.N(N), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .COEFS(A)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy));

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0, cyc = 0, out_cnt = 0;
    int last_xfer_edge = 0;
    bit b2b = 0;
    logic [N*OUT_W-1:0] exp_q[$];
    int acc_q[$];
    logic prev_valid = 0;
    logic [N*OUT_W-1:0] prev_c = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [N*OUT_W-1:0] pack(input logic [15:0] c0, c1, c2);
        return {c2, c1, c0};
    endfunction

    // Monitor samples 1 time unit after the falling edge so stimulus driven on that edge has settled
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            acc_q.delete();
            prev_valid = 0;
        end else begin
            if (in_valid && in_ready) begin
                if (b2b) check("b2b_accept_gap", 64'(cyc + 1 - last_xfer_edge), 64'd1);
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) fail_now("latency_no_accept");
                else check("latency", 64'(cyc - acc_q.pop_front()), 64'(N * N));
            end
            if (out_valid && prev_valid) begin
                check("hold_out_c", 64'(out_c), 64'(prev_c));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_output");
                else check("result", 64'(out_c), 64'(exp_q.pop_front()));
                last_xfer_edge = cyc + 1;
                out_cnt++;
            end
            prev_valid = out_valid;
            prev_c     = out_c;
        end
    end

    task automatic send(input logic [N*IN_W-1:0] b);
        int n = 0;
        in_valid = 1;
        in_b     = b;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("send_accept");
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (out_cnt < target && n < 200) begin @(negedge clk); n++; end
        if (out_cnt < target) fail_now("wait_out");
        @(negedge clk);
    endtask

    logic [N*OUT_W-1:0] exp111, expf;
    initial begin
`ifdef MATRIX_VEC_SAT_EN
        exp111 = pack(16'd65535, 16'd65535, 16'd65535);
        expf   = pack(16'd65535, 16'd65535, 16'd65535);
`else
        exp111 = pack(16'd49429, 16'd31956, 16'd8463);
        expf   = pack(16'd20539, 16'd20588, 16'd61409);
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // unit vector selects column 0
        exp_q.push_back(pack(16'd2755, 16'd21889, 16'd10840));
        send(12'h001);
        check("busy_calc", 64'(busy), 64'd1);
        wait_out(1);
        check("idle_after_xfer", 64'(in_ready), 64'd1);

        exp_q.push_back(exp111);
        send(12'h111);
        wait_out(2);

        // backpressure: hold DONE for 20 cycles and try to sneak in a vector
        out_ready = 0;
        exp_q.push_back(expf);
        send(12'hFFF);
        repeat (12) @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        in_valid = 1; in_b = 12'h111;
        @(negedge clk);
        in_valid = 0;
        repeat (20) @(negedge clk);
        check("bp_still_valid", 64'(out_valid), 64'd1);
        out_ready = 1;
        wait_out(3);
        check("bp_single_xfer", 64'(out_valid), 64'd0);

        // reset in the middle of a calculation
        send(12'h111);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_c", 64'(out_c), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        check("abort_no_output", 64'(out_cnt), 64'd3);
        check("abort_idle", 64'(in_ready), 64'd1);

        // back-to-back with in_valid held high
        exp_q.push_back(pack(16'd2755, 16'd21889, 16'd10840));
        exp_q.push_back(pack(16'd0, 16'd0, 16'd0));
        in_valid = 1; in_b = 12'h001;
        @(negedge clk);
        in_b = 12'h000;
        b2b  = 1;
        begin
            int n = 0;
            while (!in_ready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) fail_now("b2b_second_accept");
        end
        @(negedge clk);
        in_valid = 0;
        wait_out(5);
        b2b = 0;
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
